// File: rtl/mult_div_if.sv
// Handshake/operand/result bundle between the control unit (master) and mult_div_unit (slave).
interface mult_div_if #(
   parameter int WIDTH = 32
);
   logic             start_mult;
   logic             start_div;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start_mult, start_div, a, b,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start_mult, start_div, a, b,
      output busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring) unit owning the HI/LO registers.
// Optional macro MULTDIV_DIVZERO_EXC_EN: divide-by-zero is flagged in IDLE instead of being executed.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      reset,
   mult_div_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

   state_t           state, state_nx;
   logic [4:0]       cnt;
   logic [WIDTH-1:0] p, q, m;
   logic             qm1;
   logic             is_div, neg_q, neg_r;
   logic [WIDTH-1:0] hi_r, lo_r;
   logic             done_r;
   logic             accept_mult, accept_div;
   logic [WIDTH:0]   booth_sum, trial;
   logic [WIDTH-1:0] a_mag, b_mag;
`ifdef MULTDIV_DIVZERO_EXC_EN
   logic             dz_hit;
   logic             dz_r;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      accept_mult = 1'b0;
      accept_div  = 1'b0;
`ifdef MULTDIV_DIVZERO_EXC_EN
      dz_hit      = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (bus.start_mult) begin
               accept_mult = 1'b1;
               state_nx    = MULT;
            end else if (bus.start_div) begin
               accept_div = 1'b1;
`ifdef MULTDIV_DIVZERO_EXC_EN
               if (bus.b == '0) begin
                  accept_div = 1'b0;
                  dz_hit     = 1'b1;
               end
`endif
               if (accept_div) state_nx = DIV;
            end
         end
         MULT, DIV: if (cnt == 5'd31) state_nx = FIX;
         FIX:       state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Booth step uses a sign-extended (WIDTH+1)-bit sum so a = 0x80000000 cannot overflow P.
   always_comb begin
      a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
      b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;
      case ({q[0], qm1})
         2'b01:   booth_sum = {p[WIDTH-1], p} + {m[WIDTH-1], m};
         2'b10:   booth_sum = {p[WIDTH-1], p} - {m[WIDTH-1], m};
         default: booth_sum = {p[WIDTH-1], p};
      endcase
      trial = {p, q[WIDTH-1]} - {1'b0, m};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         p      <= '0;
         q      <= '0;
         m      <= '0;
         qm1    <= 1'b0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
         done_r <= 1'b0;
`ifdef MULTDIV_DIVZERO_EXC_EN
         dz_r   <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
`ifdef MULTDIV_DIVZERO_EXC_EN
         dz_r   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               cnt <= '0;
               if (accept_mult) begin
                  p      <= '0;
                  q      <= bus.b;
                  m      <= bus.a;
                  qm1    <= 1'b0;
                  is_div <= 1'b0;
               end else if (accept_div) begin
                  p      <= '0;
                  q      <= a_mag;
                  m      <= b_mag;
                  is_div <= 1'b1;
                  neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  neg_r  <= bus.a[WIDTH-1];
               end
`ifdef MULTDIV_DIVZERO_EXC_EN
               if (dz_hit) begin
                  done_r <= 1'b1;
                  dz_r   <= 1'b1;
               end
`endif
            end
            MULT: begin
               p   <= booth_sum[WIDTH:1];
               q   <= {booth_sum[0], q[WIDTH-1:1]};
               qm1 <= q[0];
               cnt <= cnt + 5'd1;
            end
            DIV: begin
               if (!trial[WIDTH]) begin
                  p <= trial[WIDTH-1:0];
                  q <= {q[WIDTH-2:0], 1'b1};
               end else begin
                  p <= {p[WIDTH-2:0], q[WIDTH-1]};
                  q <= {q[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + 5'd1;
            end
            FIX: begin
               if (is_div) begin
                  hi_r <= neg_r ? -p : p;
                  lo_r <= neg_q ? -q : q;
               end else begin
                  hi_r <= p;
                  lo_r <= q;
               end
               done_r <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;
`ifdef MULTDIV_DIVZERO_EXC_EN
   assign bus.div_zero = dz_r;
`else
   assign bus.div_zero = 1'b0;
`endif
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random MULT/DIV against a 64-bit arithmetic model.
module tb_mult_div_unit;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   mult_div_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed 64-bit arithmetic, truncating division, b==0 handled by the documented rule.
   function automatic void model(input bit is_mult, input logic [31:0] av, input logic [31:0] bv,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint sa, sb, pr, qu, re;
      logic [63:0] wide;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      if (is_mult) begin
         pr   = sa * sb;
         wide = pr;
         eh   = wide[63:32];
         el   = wide[31:0];
      end else if (sb == 0) begin
         eh = av;
         el = (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
      end else begin
         qu   = sa / sb;
         re   = sa % sb;
         wide = qu;
         el   = wide[31:0];
         wide = re;
         eh   = wide[31:0];
      end
   endfunction

   task automatic run_op(input string tag, input bit mult, input bit both,
                         input logic [31:0] av, input logic [31:0] bv, input int poke);
      logic [31:0] eh, el, old_hi, old_lo;
      int cycles, busy_n;
      bit hold_ok, dz_seen;
      model(mult | both, av, bv, eh, el);
      @(negedge clk);
      old_hi = bus.hi;
      old_lo = bus.lo;
      bus.a          = av;
      bus.b          = bv;
      bus.start_mult = mult | both;
      bus.start_div  = !mult | both;
      @(negedge clk);
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      bus.a          = $urandom;
      bus.b          = $urandom;
      cycles  = 0;
      busy_n  = 0;
      hold_ok = 1'b1;
      dz_seen = 1'b0;
      while (!bus.done && cycles < 100) begin
         if (bus.busy) busy_n++;
         if (bus.hi !== old_hi || bus.lo !== old_lo) hold_ok = 1'b0;
         if (bus.div_zero) dz_seen = 1'b1;
         bus.start_mult = (cycles == poke);
         @(negedge clk);
         cycles++;
      end
      bus.start_mult = 1'b0;
      check({tag, ".latency"}, cycles, 33);
      check({tag, ".busy_cycles"}, busy_n, 33);
      check({tag, ".busy_at_done"}, {31'b0, bus.busy}, 32'd0);
      check({tag, ".hi"}, bus.hi, eh);
      check({tag, ".lo"}, bus.lo, el);
      check({tag, ".hold_old"}, {31'b0, hold_ok}, 32'd1);
      check({tag, ".div_zero"}, {31'b0, dz_seen | bus.div_zero}, 32'd0);
      @(negedge clk);
      check({tag, ".done_pulse"}, {31'b0, bus.done}, 32'd0);
      check({tag, ".idle_after"}, {31'b0, bus.busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb, keep_hi, keep_lo;
      bit rm;
      errors = 0;
      checks = 0;
      reset          = 1'b1;
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      repeat (3) @(negedge clk);
      check("rst.busy", {31'b0, bus.busy}, 32'd0);
      check("rst.done", {31'b0, bus.done}, 32'd0);
      check("rst.div_zero", {31'b0, bus.div_zero}, 32'd0);
      check("rst.hi", bus.hi, 32'd0);
      check("rst.lo", bus.lo, 32'd0);
      reset = 1'b0;

      run_op("mul_7x-3", 1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, -1);
      check("mul_7x-3.hi_const", bus.hi, 32'hFFFF_FFFF);
      check("mul_7x-3.lo_const", bus.lo, 32'hFFFF_FFEB);
      run_op("mul_min2", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1);
      check("mul_min2.hi_const", bus.hi, 32'h4000_0000);
      run_op("mul_m1m1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
      run_op("div_-7/2", 1'b0, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, -1);
      check("div_-7/2.hi_const", bus.hi, 32'hFFFF_FFFF);
      run_op("div_7/-2", 1'b0, 1'b0, 32'h0000_0007, 32'hFFFF_FFFE, -1);
      check("div_7/-2.lo_const", bus.lo, 32'hFFFF_FFFD);
      run_op("div_ovf", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1);
      check("div_ovf.lo_const", bus.lo, 32'h8000_0000);
      run_op("div_poke", 1'b0, 1'b0, 32'd1000, 32'd7, 10);
      run_op("both_start", 1'b0, 1'b1, 32'd6, 32'd7, -1);
      check("both_start.lo_const", bus.lo, 32'd42);

`ifdef MULTDIV_DIVZERO_EXC_EN
      keep_hi = bus.hi;
      keep_lo = bus.lo;
      @(negedge clk);
      bus.a = 32'd5;
      bus.b = 32'd0;
      bus.start_div = 1'b1;
      @(negedge clk);
      bus.start_div = 1'b0;
      check("dz.done", {31'b0, bus.done}, 32'd1);
      check("dz.flag", {31'b0, bus.div_zero}, 32'd1);
      check("dz.busy", {31'b0, bus.busy}, 32'd0);
      @(negedge clk);
      check("dz.done_low", {31'b0, bus.done}, 32'd0);
      check("dz.flag_low", {31'b0, bus.div_zero}, 32'd0);
      check("dz.hi_keep", bus.hi, keep_hi);
      check("dz.lo_keep", bus.lo, keep_lo);
`else
      run_op("div_5/0", 1'b0, 1'b0, 32'd5, 32'd0, -1);
      check("div_5/0.lo_const", bus.lo, 32'hFFFF_FFFF);
      keep_hi = 32'd5;
      keep_lo = 32'hFFFF_FFFF;
      check("div_5/0.hi_const", bus.hi, keep_hi);
`endif

      // Reset during a MULT discards the operation.
      @(negedge clk);
      bus.a = 32'h1234_5678;
      bus.b = 32'h0000_0100;
      bus.start_mult = 1'b1;
      @(negedge clk);
      bus.start_mult = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid.busy", {31'b0, bus.busy}, 32'd0);
      check("rst_mid.done", {31'b0, bus.done}, 32'd0);
      check("rst_mid.hi", bus.hi, 32'd0);
      check("rst_mid.lo", bus.lo, 32'd0);
      run_op("mul_3x4", 1'b1, 1'b0, 32'd3, 32'd4, -1);

      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         rb = $urandom;
         rm = 1'($urandom_range(0, 1));
`ifdef MULTDIV_DIVZERO_EXC_EN
         if (rb == 32'd0) rb = 32'd1;
`endif
         if (i % 4 == 3) ra = {ra[31], 31'd0};
         run_op(rm ? "rnd_mul" : "rnd_div", rm, 1'b0, ra, rb, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
